ll3_h_lowpass3: RTL
===================

Name: ll3_h_lowpass3

Overview:
- Horizontal 3-tap [1 2 1]/4 low-pass stage feeding the LL3_H pass-through actor in the visual-saliency pyramid.
- Consumes one raster-order pixel stream on In1 and produces one filtered pixel per input pixel on Out1.
- Uses the same SEND/ACK/RDY/COUNT token protocol as LL3_H.
- Row borders use replicate-edge handling; rows are ROW_WIDTH pixels long.

Parameters:
- DATA_W, 16, pixel width (unsigned); also the width of both COUNT buses.
- ROW_WIDTH, 512, pixels per row; legal range 1..65535.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  reset, asynchronous, active-high.
- In1_DATA  input  DATA_W  input pixel.
- In1_SEND  input  1  upstream token valid.
- In1_COUNT  input  DATA_W  upstream token count; ignored.
- In1_ACK  output  1  one-cycle consume pulse.
- Out1_RDY  input  1  downstream can accept one token this cycle.
- Out1_ACK  input  1  downstream acknowledge; ignored (same as LL3_H).
- Out1_DATA  output  DATA_W  filtered pixel.
- Out1_SEND  output  1  one-cycle token-valid pulse.
- Out1_COUNT  output  DATA_W  constant 1.

Behaviour:
- Reset values: In1_ACK=0, Out1_SEND=0, Out1_DATA=0, Out1_COUNT=1, state=FIRST, col=0, prev=cur=0.
- Registers:
  - prev, cur: DATA_W each.
  - col: 16-bit index of the next input pixel within the row.
  - state: FIRST / RUN / FLUSH.
- Filter f(a,b,c) = (a + 2b + c + 2) >> 2:
  - Computed in DATA_W+2 bits, rounds half up.
  - Result always fits DATA_W bits; a saturation check is not needed.
- FIRST:
  - fire = In1_SEND.
  - On fire: In1_ACK=1, prev<=cur<=In1_DATA, col<=1. No output.
  - If ROW_WIDTH==1, go to FLUSH; otherwise go to RUN.
- RUN:
  - fire = In1_SEND & Out1_RDY.
  - On fire with x=In1_DATA: In1_ACK=1, emit f(prev,cur,x), prev<=cur, cur<=x, col<=col+1.
  - If col==ROW_WIDTH-1 at fire, go to FLUSH.
- FLUSH:
  - fire = Out1_RDY.
  - On fire: emit f(prev,cur,cur), col<=0, go to FIRST. No input is consumed.
- In1_ACK is combinational (= fire while in FIRST/RUN). Assert it only in a fire cycle and for exactly one cycle.
- Emit means Out1_SEND<=1 and Out1_DATA<=result, both registered. The token appears on the cycle after fire.
- In every non-emit cycle Out1_SEND<=0 and Out1_DATA holds its last value.
- Out1_RDY is sampled only at fire; Out1_SEND must never assert for a fire that lacked RDY.
- Throughput:
  - RUN sustains 1 pixel/cycle.
  - Each row costs ROW_WIDTH+1 fire cycles (one for FIRST, ROW_WIDTH-1 in RUN, one for FLUSH).
  - Every row emits exactly ROW_WIDTH outputs.
- Latency: the first output of a row appears on the cycle after the second pixel is consumed (or after FLUSH when ROW_WIDTH==1).
- The last pixel of a row and the first pixel of the next row are never combined. FLUSH always separates the two rows.
- In1_SEND high with Out1_RDY low in RUN: stall with no ACK; state and registers hold.
- Asserting RESET mid-row discards the partial row, forces Out1_SEND low immediately, and returns to FIRST.

Optional Feature:
- Macro: LL3_H_LOWPASS3_BYPASS_EN.
- Defined:
  - Adds input port BYPASS (1 bit), sampled only on a fire in FIRST and latched for the whole row.
  - When latched high, every pixel is forwarded unfiltered. Each input fire needs In1_SEND & Out1_RDY, including the first pixel, with one emit per fire.
  - Bypass rows use no FLUSH cycle. After ROW_WIDTH fires the block returns to FIRST.
- Undefined: no port and no bypass logic; behaviour is exactly as described above.

Decomposition:
- Package ll3_h_lowpass3_pkg holds:
  - the state enum (FIRST, RUN, FLUSH);
  - the rounding constant 2;
  - the shift amount 2;
  - the DATA_W default.
- One sub-module: ll3_h_lowpass3_kernel, a purely combinational f(a,b,c) with DATA_W parameter. The top module holds the FSM, the registers and the handshake.

Test Plan:
- ROW_WIDTH=4, input 0,4,8,12 with RDY held high → outputs 1,4,8,11. The fifth output token does not exist; Out1_SEND pulses exactly 4 times.
- ROW_WIDTH=1, input 100,200 → outputs 100,200. FLUSH occurs after each pixel; In1_ACK never pulses in a FLUSH cycle.
- ROW_WIDTH=3, all 0xFFFF → all outputs 0xFFFF (no overflow). Input 0,0,1 → outputs 0,0,1 (rounding check, (0+0+1+2)>>2=0 then (0+2+1+2)>>2=1).
- ROW_WIDTH=4, Out1_RDY low for 3 cycles while In1_SEND is high mid-row → no ACK and no SEND during the stall. The output sequence is identical to the no-stall run.
- Two back-to-back rows of ROW_WIDTH=2, input 10,20 then 90,50:
  - Outputs are 13,18 then 80,60.
  - The second row shows no contamination from the first.
- RESET asserted after 2 of 4 pixels, then a fresh row 0,4,8,12 → immediate Out1_SEND=0, then outputs 1,4,8,11.

Source files
------------

// File: rtl/ll3_h_lowpass3_pkg.sv
// ll3_h_lowpass3_pkg: shared state encoding and filter constants for the LL3_H [1 2 1]/4 low-pass stage
package ll3_h_lowpass3_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int RND = 2;
  localparam int SHIFT = 2;
  typedef enum logic [1:0] {ST_FIRST, ST_RUN, ST_FLUSH} state_t;
endpackage

// File: rtl/ll3_h_lowpass3_kernel.sv
// ll3_h_lowpass3_kernel: combinational (a + 2b + c + 2) >> 2, rounding half up
module ll3_h_lowpass3_kernel
  import ll3_h_lowpass3_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] y
);
  // two guard bits hold the full weighted sum, so the shifted result always fits DATA_W
  logic [DATA_W+1:0] sum;
  assign sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + (DATA_W+2)'(RND);
  assign y = sum[SHIFT +: DATA_W];
endmodule

// File: rtl/ll3_h_lowpass3.sv
// ll3_h_lowpass3: horizontal [1 2 1]/4 replicate-edge filter on the LL3_H token stream; LL3_H_LOWPASS3_BYPASS_EN adds per-row BYPASS
module ll3_h_lowpass3
  import ll3_h_lowpass3_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROW_WIDTH = 512
) (
  input  logic              CLK,
  input  logic              RESET,
`ifdef LL3_H_LOWPASS3_BYPASS_EN
  input  logic              BYPASS,
`endif
  input  logic [DATA_W-1:0] In1_DATA,
  input  logic              In1_SEND,
  input  logic [DATA_W-1:0] In1_COUNT,
  output logic              In1_ACK,
  input  logic              Out1_RDY,
  input  logic              Out1_ACK,
  output logic [DATA_W-1:0] Out1_DATA,
  output logic              Out1_SEND,
  output logic [DATA_W-1:0] Out1_COUNT
);
  localparam logic [15:0] LAST = 16'(ROW_WIDTH - 1);
  state_t state_q, state_d;
  logic [15:0] col_q, col_d;
  logic [DATA_W-1:0] prev_q, prev_d, cur_q, cur_d, data_q, data_d, kc, f;
  logic send_q, send_d;
  logic unused_ok;
  assign unused_ok = ^{In1_COUNT, Out1_ACK};
  assign kc = state_q == ST_FLUSH ? cur_q : In1_DATA;
  ll3_h_lowpass3_kernel #(.DATA_W(DATA_W)) u_kernel (.a(prev_q), .b(cur_q), .c(kc), .y(f));
  assign Out1_DATA = data_q;
  assign Out1_SEND = send_q;
  assign Out1_COUNT = DATA_W'(1);
`ifdef LL3_H_LOWPASS3_BYPASS_EN
  logic byp_q, byp_d, byp_row, byp_fire, byp_last;
  assign byp_row = (state_q == ST_FIRST && BYPASS) || (state_q == ST_RUN && byp_q);
  assign byp_fire = byp_row && In1_SEND && Out1_RDY;
  assign byp_last = state_q == ST_FIRST ? ROW_WIDTH == 1 : col_q == LAST;
`endif
  // row FSM: prime the window in FIRST, stream in RUN, emit the replicated right edge in FLUSH
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    prev_d = prev_q;
    cur_d = cur_q;
    data_d = data_q;
    send_d = 1'b0;
    In1_ACK = 1'b0;
    case (state_q)
      ST_FIRST: if (In1_SEND) begin
        In1_ACK = 1'b1;
        prev_d = In1_DATA;
        cur_d = In1_DATA;
        col_d = 16'd1;
        state_d = ROW_WIDTH == 1 ? ST_FLUSH : ST_RUN;
      end
      ST_RUN: if (In1_SEND && Out1_RDY) begin
        In1_ACK = 1'b1;
        send_d = 1'b1;
        data_d = f;
        prev_d = cur_q;
        cur_d = In1_DATA;
        col_d = col_q + 16'd1;
        state_d = col_q == LAST ? ST_FLUSH : ST_RUN;
      end
      ST_FLUSH: if (Out1_RDY) begin
        send_d = 1'b1;
        data_d = f;
        col_d = 16'd0;
        state_d = ST_FIRST;
      end
      default: state_d = ST_FIRST;
    endcase
`ifdef LL3_H_LOWPASS3_BYPASS_EN
    if (byp_row) begin
      In1_ACK = byp_fire;
      send_d = byp_fire;
      data_d = byp_fire ? In1_DATA : data_q;
      prev_d = prev_q;
      cur_d = cur_q;
      col_d = byp_fire ? (byp_last ? 16'd0 : col_q + 16'd1) : col_q;
      state_d = byp_fire ? (byp_last ? ST_FIRST : ST_RUN) : state_q;
    end
    byp_d = state_q == ST_FIRST && In1_ACK ? BYPASS : byp_q;
`endif
  end
  // state and output registers; reset drops any partial row and the output token at once
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_FIRST;
      col_q <= '0;
      prev_q <= '0;
      cur_q <= '0;
      data_q <= '0;
      send_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      prev_q <= prev_d;
      cur_q <= cur_d;
      data_q <= data_d;
      send_q <= send_d;
    end
  end
`ifdef LL3_H_LOWPASS3_BYPASS_EN
  // bypass mode latched for the whole row at its first fire
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) byp_q <= 1'b0;
    else byp_q <= byp_d;
  end
`endif
endmodule
